fir_tap_scheduler: RTL and testbench

//  Per-sample sequencer for the FIR lowpass datapath (coefficient ROM, sample delay-line RAM, MAC).
//  - On each accepted input sample: writes the sample into a circular delay line in RAM.
//  - Walks all NTAPS coefficient/sample address pairs.
//  - Drives MAC clear/enable strobes aligned to memory read latency, then flags the accumulator result valid.

---
 rtl/fir_pkg.sv | 22 ++
 rtl/fir_strobe_delay.sv | 30 +++
 rtl/fir_tap_scheduler.sv | 117 +++++++++++
 tb/tb_fir_tap_scheduler.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and default constants for the FIR tap scheduler.
// Holds the sequencer state encoding and default datapath sizing.
package fir_pkg;

  localparam int NTAPS_DEF   = 62;
  localparam int AW_DEF      = 7;
  localparam int MEM_LAT_DEF = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    MAC   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fir_strobe_delay.sv
// Aligns the MAC strobes with the ROM/RAM read latency.
// Carries {issue, first} through a LAT-deep register chain.
module fir_strobe_delay #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic issue,
  input  logic first,
  output logic mac_en,
  output logic mac_clear
);

  logic [LAT-1:0][1:0] pipe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe <= '0;
    end else begin
      pipe[0] <= {issue, first};
      for (int i = 1; i < LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign mac_en    = pipe[LAT-1][1];
  assign mac_clear = pipe[LAT-1][0];

endmodule

// File: rtl/fir_tap_scheduler.sv
// Per-sample sequencer: writes each sample into the circular
// delay line, walks all taps and strobes the MAC.
module fir_tap_scheduler
  import fir_pkg::*;
#(
  parameter int NTAPS   = NTAPS_DEF,
  parameter int AW      = AW_DEF,
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sample_valid,
  output logic          sample_ready,
  output logic [AW-1:0] a_rom,
  output logic [AW-1:0] a_ram,
  output logic          wren,
  output logic          mac_clear,
  output logic          mac_en,
  output logic          acc_valid,
  output logic          busy
);

  localparam int DW = cnt_w(MEM_LAT);
  localparam logic [AW-1:0] KLAST = AW'(NTAPS - 1);
  localparam logic [DW-1:0] DLAST = DW'(MEM_LAT - 1);
  localparam logic [AW:0]   NT    = (AW+1)'(NTAPS);

  state_t        state, state_nx;
  logic [AW-1:0] k, k_nx;
  logic [AW-1:0] wptr, wptr_nx;
  logic [DW-1:0] dcnt, dcnt_nx;
  logic [AW:0]   diff;
  logic          issue, first;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      k     <= '0;
      wptr  <= '0;
      dcnt  <= '0;
    end else begin
      state <= state_nx;
      k     <= k_nx;
      wptr  <= wptr_nx;
      dcnt  <= dcnt_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    k_nx         = k;
    wptr_nx      = wptr;
    dcnt_nx      = dcnt;
    sample_ready = 1'b0;
    a_rom        = '0;
    a_ram        = '0;
    wren         = 1'b0;
    acc_valid    = 1'b0;
    busy         = 1'b0;
    issue        = 1'b0;
    first        = 1'b0;
    diff         = '0;
    case (state)
      IDLE: begin
        sample_ready = 1'b1;
        if (sample_valid) state_nx = WRITE;
      end
      WRITE: begin
        busy     = 1'b1;
        wren     = 1'b1;
        a_ram    = wptr;
        k_nx     = '0;
        state_nx = MAC;
      end
      MAC: begin
        busy  = 1'b1;
        a_rom = k;
        // Newest sample sits at wptr; older taps walk backwards.
        if (wptr >= k) diff = {1'b0, wptr} - {1'b0, k};
        else           diff = {1'b0, wptr} + NT - {1'b0, k};
        a_ram = diff[AW-1:0];
        issue = 1'b1;
        first = (k == '0);
        k_nx  = k + 1'b1;
        if (k == KLAST) begin
          k_nx     = '0;
          dcnt_nx  = '0;
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        busy    = 1'b1;
        dcnt_nx = dcnt + 1'b1;
        if (dcnt == DLAST) state_nx = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        acc_valid = 1'b1;
        wptr_nx   = (wptr == KLAST) ? '0 : wptr + 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  fir_strobe_delay #(
    .LAT (MEM_LAT)
  ) u_strobe (
    .clk       (clk),
    .reset     (reset),
    .issue     (issue),
    .first     (first),
    .mac_en    (mac_en),
    .mac_clear (mac_clear)
  );

endmodule

// File: tb/tb_fir_tap_scheduler.sv
// Randomised bench for fir_tap_scheduler against a per-sample
// schedule model, in three configurations side by side.
module tb_fir_tap_scheduler;

  typedef struct packed {
    logic       rdy;
    logic [6:0] a_rom;
    logic [6:0] a_ram;
    logic       wren;
    logic       clr;
    logic       en;
    logic       accv;
    logic       busy;
  } obs_t;

  logic       clk;
  logic       reset;
  logic [2:0] sv;

  logic       rdy0, wren0, clr0, en0, accv0, busy0;
  logic [2:0] rom0, ram0;
  logic       rdy1, wren1, clr1, en1, accv1, busy1;
  logic [6:0] rom1, ram1;
  logic       rdy2, wren2, clr2, en2, accv2, busy2;
  logic [2:0] rom2, ram2;

  int n_chk  = 0;
  int n_fail = 0;

  int ntaps [3] = '{4, 62, 4};
  int lat   [3] = '{1, 1, 2};
  int off   [3];
  int wp    [3];
  bit hold;
  bit rst_done;

  fir_tap_scheduler #(.NTAPS(4), .AW(3), .MEM_LAT(1)) d0 (
    .clk(clk), .reset(reset), .sample_valid(sv[0]),
    .sample_ready(rdy0), .a_rom(rom0), .a_ram(ram0),
    .wren(wren0), .mac_clear(clr0), .mac_en(en0),
    .acc_valid(accv0), .busy(busy0)
  );

  fir_tap_scheduler d1 (
    .clk(clk), .reset(reset), .sample_valid(sv[1]),
    .sample_ready(rdy1), .a_rom(rom1), .a_ram(ram1),
    .wren(wren1), .mac_clear(clr1), .mac_en(en1),
    .acc_valid(accv1), .busy(busy1)
  );

  fir_tap_scheduler #(.NTAPS(4), .AW(3), .MEM_LAT(2)) d2 (
    .clk(clk), .reset(reset), .sample_valid(sv[2]),
    .sample_ready(rdy2), .a_rom(rom2), .a_ram(ram2),
    .wren(wren2), .mac_clear(clr2), .mac_en(en2),
    .acc_valid(accv2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic obs_t observe(input int d);
    obs_t o;
    case (d)
      0: o = {rdy0, 4'b0, rom0, 4'b0, ram0,
              wren0, clr0, en0, accv0, busy0};
      1: o = {rdy1, rom1, ram1,
              wren1, clr1, en1, accv1, busy1};
      default: o = {rdy2, 4'b0, rom2, 4'b0, ram2,
                    wren2, clr2, en2, accv2, busy2};
    endcase
    return o;
  endfunction

  // o = cycles since the accepting edge; o < 1 means idle.
  function automatic obs_t model(input int n, input int l,
                                 input int o, input int w);
    obs_t e;
    int   k;
    e = '0;
    k = o - 2;
    if (o < 1) begin
      e.rdy = 1'b1;
    end else begin
      e.busy = 1'b1;
      if (o == 1) begin
        e.wren  = 1'b1;
        e.a_ram = 7'(w);
      end else if (o <= n + 1) begin
        e.a_rom = 7'(k);
        e.a_ram = 7'((w - k + n) % n);
      end
      e.en   = (o >= 2 + l) && (o <= n + 1 + l);
      e.clr  = (o == 2 + l);
      e.accv = (o == n + l + 2);
    end
    return e;
  endfunction

  task automatic check_all_idle(input string tag);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s_d%0d", tag, d),
            32'(observe(d)), 32'(model(ntaps[d], lat[d], -1, 0)));
    end
  endtask

  initial begin
    reset    = 1'b1;
    sv       = '0;
    hold     = 1'b0;
    rst_done = 1'b0;
    for (int d = 0; d < 3; d++) begin
      off[d] = -1;
      wp[d]  = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_idle("reset");
    reset = 1'b0;

    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        check($sformatf("d%0d_c%0d", d, cyc), 32'(observe(d)),
              32'(model(ntaps[d], lat[d], off[d], wp[d])));
      end

      if (!rst_done && cyc > 300 && off[0] == 4) begin
        sv = '0;
        #1 reset = 1'b1;
        #1 check_all_idle("rst_async");
        @(posedge clk);
        #1 check_all_idle("rst_hold");
        reset = 1'b0;
        for (int d = 0; d < 3; d++) begin
          off[d] = -1;
          wp[d]  = 0;
        end
        rst_done = 1'b1;
        continue;
      end

      hold = (cyc >= 600 && cyc < 850);
      for (int d = 0; d < 3; d++) begin
        sv[d] = hold ? 1'b1 : ($urandom_range(0, 3) == 0);
        if (off[d] < 1) begin
          off[d] = sv[d] ? 1 : -1;
        end else if (off[d] == ntaps[d] + lat[d] + 2) begin
          off[d] = -1;
          wp[d]  = (wp[d] + 1) % ntaps[d];
        end else begin
          off[d]++;
        end
      end
    end

    check("rst_seen", 32'(rst_done), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
